// File: rtl/cache_pkg.sv
// Shared dcache-side encodings and the posted-write entry layout.
package cache_pkg;

  // Access type encodings shared by the read and write request ports
  localparam logic [2:0] TYPE_BYTE = 3'b000;
  localparam logic [2:0] TYPE_HALF = 3'b001;
  localparam logic [2:0] TYPE_WORD = 3'b010;
  localparam logic [2:0] TYPE_LINE = 3'b100;

  localparam int LINE_BYTES = 16;
  localparam int WR_ENTRY_W = 167;

  // One buffered write; first field lands in the MSBs
  typedef struct packed {
    logic [2:0]   wtype;
    logic [31:0]  addr;
    logic [3:0]   wstrb;
    logic [127:0] data;
  } wr_entry_t;

  // Bit position of addr[0] inside a packed wr_entry_t
  localparam int ENTRY_ADDR_LSB = 132;

  function automatic logic is_line(input logic [2:0] t);
    return (t == TYPE_LINE);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Circular FIFO that also exposes per-slot valid bits and a key slice of
// every slot, so the owner can compare incoming requests against all
// pending entries.
module sync_fifo #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,
  parameter int KEY_LSB = 0,
  parameter int KEY_W   = WIDTH,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        push,
  input  logic [WIDTH-1:0]            push_data,
  input  logic                        pop,
  output logic [WIDTH-1:0]            head_data,
  output logic [CNT_W-1:0]            count,
  output logic [DEPTH-1:0]            slot_valid,
  output logic [DEPTH-1:0][KEY_W-1:0] slot_key
);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [PTR_W-1:0]            head;
  logic [PTR_W-1:0]            tail;

  // Storage, pointer and occupancy update; callers never push when full
  // nor pop when empty, so push and pop never touch the same slot.
  always_ff @(posedge clock) begin
    if (reset) begin
      mem        <= {(DEPTH*WIDTH){1'b0}};
      slot_valid <= {DEPTH{1'b0}};
      head       <= {PTR_W{1'b0}};
      tail       <= {PTR_W{1'b0}};
      count      <= {CNT_W{1'b0}};
    end else begin
      if (push) begin
        mem[tail]        <= push_data;
        slot_valid[tail] <= 1'b1;
        tail             <= tail + 1'b1;
      end
      if (pop) begin
        slot_valid[head] <= 1'b0;
        head             <= head + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head_data = mem[head];

  // Extract the compare key of every slot
  always_comb begin
    slot_key = {(DEPTH*KEY_W){1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      slot_key[i] = mem[i][KEY_LSB +: KEY_W];
    end
  end

endmodule

// File: rtl/dcache_wr_buf.sv
// Posted-write buffer between the dcache and the AXI bridge. Writes are
// queued and drained in order; reads pass straight through unless they
// would overtake a pending write to the same line, or are uncached while
// any write is still pending.
module dcache_wr_buf
  import cache_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int MATCH_LSB = $clog2(LINE_BYTES)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         up_rd_req,
  input  logic [2:0]   up_rd_type,
  input  logic [31:0]  up_rd_addr,
  output logic         up_rd_rdy,
  output logic         dn_rd_req,
  output logic [2:0]   dn_rd_type,
  output logic [31:0]  dn_rd_addr,
  input  logic         dn_rd_rdy,
  input  logic         up_wr_req,
  input  logic [2:0]   up_wr_type,
  input  logic [31:0]  up_wr_addr,
  input  logic [3:0]   up_wr_wstrb,
  input  logic [127:0] up_wr_data,
  output logic         up_wr_rdy,
  output logic         dn_wr_req,
  output logic [2:0]   dn_wr_type,
  output logic [31:0]  dn_wr_addr,
  output logic [3:0]   dn_wr_wstrb,
  output logic [127:0] dn_wr_data,
  input  logic         dn_wr_rdy,
  output logic         write_buffer_empty
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int KEY_W = 32 - MATCH_LSB;

  wr_entry_t                   push_entry;
  wr_entry_t                   head_entry;
  logic [CNT_W-1:0]            count;
  logic [DEPTH-1:0]            slot_valid;
  logic [DEPTH-1:0][KEY_W-1:0] slot_key;
  logic [KEY_W-1:0]            rd_key;
  logic                        push_acc;
  logic                        pop_acc;
  logic                        buf_hit;
  logic                        order_hit;
  logic                        push_hit;
  logic                        hazard;

  // Full blocks pushes even when a pop happens in the same cycle
  assign up_wr_rdy          = (count != CNT_W'(DEPTH));
  assign push_acc           = up_wr_req && up_wr_rdy;
  assign dn_wr_req          = (count != CNT_W'(0));
  assign pop_acc            = dn_wr_req && dn_wr_rdy;
  assign write_buffer_empty = (count == CNT_W'(0));

  assign push_entry = '{wtype: up_wr_type, addr: up_wr_addr,
                        wstrb: up_wr_wstrb, data: up_wr_data};

  sync_fifo #(
    .WIDTH   (WR_ENTRY_W),
    .DEPTH   (DEPTH),
    .KEY_LSB (ENTRY_ADDR_LSB + MATCH_LSB),
    .KEY_W   (KEY_W)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (push_acc),
    .push_data  (push_entry),
    .pop        (pop_acc),
    .head_data  (head_entry),
    .count      (count),
    .slot_valid (slot_valid),
    .slot_key   (slot_key)
  );

  // Head entry drives the bridge directly from storage
  assign dn_wr_type  = head_entry.wtype;
  assign dn_wr_addr  = head_entry.addr;
  assign dn_wr_wstrb = head_entry.wstrb;
  assign dn_wr_data  = head_entry.data;

  assign rd_key = up_rd_addr[31:MATCH_LSB];

  // Same-line match against every pending entry
  always_comb begin
    buf_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      buf_hit = buf_hit | (slot_valid[i] && (slot_key[i] == rd_key));
    end
  end

  // Uncached reads stay strictly behind all pending writes; a write being
  // accepted this cycle counts as pending for both rules.
  assign order_hit = !is_line(up_rd_type) && dn_wr_req;
  assign push_hit  = push_acc &&
                     ((up_wr_addr[31:MATCH_LSB] == rd_key) || !is_line(up_rd_type));
  assign hazard    = buf_hit | order_hit | push_hit;

  assign dn_rd_req  = up_rd_req && !hazard;
  assign up_rd_rdy  = dn_rd_rdy && !hazard;
  assign dn_rd_type = up_rd_type;
  assign dn_rd_addr = up_rd_addr;

endmodule

// File: tb/tb_dcache_wr_buf.sv
// Directed bench for dcache_wr_buf with a queue-based reference model.
module tb_dcache_wr_buf;
  import cache_pkg::*;

  localparam int DEPTH = 4;
  localparam logic [127:0] D1 = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
  localparam logic [127:0] D2 = 128'hdead_beef_0000_1111_2222_3333_4444_5555;
  localparam logic [127:0] D3 = 128'hcafe_f00d_a5a5_5a5a_0f0f_f0f0_1234_5678;

  logic         clock;
  logic         reset;
  logic         up_rd_req;
  logic [2:0]   up_rd_type;
  logic [31:0]  up_rd_addr;
  logic         up_rd_rdy;
  logic         dn_rd_req;
  logic [2:0]   dn_rd_type;
  logic [31:0]  dn_rd_addr;
  logic         dn_rd_rdy;
  logic         up_wr_req;
  logic [2:0]   up_wr_type;
  logic [31:0]  up_wr_addr;
  logic [3:0]   up_wr_wstrb;
  logic [127:0] up_wr_data;
  logic         up_wr_rdy;
  logic         dn_wr_req;
  logic [2:0]   dn_wr_type;
  logic [31:0]  dn_wr_addr;
  logic [3:0]   dn_wr_wstrb;
  logic [127:0] dn_wr_data;
  logic         dn_wr_rdy;
  logic         write_buffer_empty;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]   t;
    logic [31:0]  a;
    logic [3:0]   s;
    logic [127:0] d;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] popped[$];
  bit          model_on = 1'b0;

  dcache_wr_buf #(.DEPTH(DEPTH), .MATCH_LSB(4)) dut (
    .clock(clock), .reset(reset),
    .up_rd_req(up_rd_req), .up_rd_type(up_rd_type), .up_rd_addr(up_rd_addr),
    .up_rd_rdy(up_rd_rdy), .dn_rd_req(dn_rd_req), .dn_rd_type(dn_rd_type),
    .dn_rd_addr(dn_rd_addr), .dn_rd_rdy(dn_rd_rdy),
    .up_wr_req(up_wr_req), .up_wr_type(up_wr_type), .up_wr_addr(up_wr_addr),
    .up_wr_wstrb(up_wr_wstrb), .up_wr_data(up_wr_data), .up_wr_rdy(up_wr_rdy),
    .dn_wr_req(dn_wr_req), .dn_wr_type(dn_wr_type), .dn_wr_addr(dn_wr_addr),
    .dn_wr_wstrb(dn_wr_wstrb), .dn_wr_data(dn_wr_data), .dn_wr_rdy(dn_wr_rdy),
    .write_buffer_empty(write_buffer_empty)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: in-order queue, updated on each clock edge
  always @(posedge clock) begin
    bit   do_pop;
    bit   do_push;
    ent_t e;
    if (reset) begin
      mq.delete();
      model_on = 1'b1;
    end else if (model_on) begin
      do_pop  = (mq.size() != 0) && dn_wr_rdy;
      do_push = up_wr_req && (mq.size() != DEPTH);
      if (do_pop) begin
        popped.push_back(mq[0].a);
        void'(mq.pop_front());
      end
      if (do_push) begin
        e.t = up_wr_type; e.a = up_wr_addr; e.s = up_wr_wstrb; e.d = up_wr_data;
        mq.push_back(e);
      end
    end
  end

  // Every-cycle comparison of DUT outputs against the model
  always @(negedge clock) begin
    if (model_on && !reset) begin
      bit haz;
      bit rd_unc;
      bit push_ok;
      rd_unc  = (up_rd_type != 3'b100);
      push_ok = up_wr_req && (mq.size() != DEPTH);
      haz = 1'b0;
      foreach (mq[i]) if (mq[i].a[31:4] == up_rd_addr[31:4]) haz = 1'b1;
      if (rd_unc && mq.size() != 0) haz = 1'b1;
      if (push_ok && ((up_wr_addr[31:4] == up_rd_addr[31:4]) || rd_unc)) haz = 1'b1;
      chk("cmp_wr_req", dn_wr_req, mq.size() != 0);
      chk("cmp_empty", write_buffer_empty, mq.size() == 0);
      chk("cmp_wr_rdy", up_wr_rdy, mq.size() != DEPTH);
      chk("cmp_rd_req", dn_rd_req, up_rd_req && !haz);
      chk("cmp_rd_rdy", up_rd_rdy, dn_rd_rdy && !haz);
      chk("cmp_rd_addr", dn_rd_addr, up_rd_addr);
      chk("cmp_rd_type", dn_rd_type, up_rd_type);
      if (mq.size() != 0) begin
        chk("cmp_wr_type", dn_wr_type, mq[0].t);
        chk("cmp_wr_addr", dn_wr_addr, mq[0].a);
        chk("cmp_wr_wstrb", dn_wr_wstrb, mq[0].s);
        chk("cmp_wr_data", dn_wr_data, mq[0].d);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Present one write and hold it until the buffer takes it
  task automatic push(input logic [2:0] t, input logic [31:0] a, input logic [3:0] s,
                      input logic [127:0] d, input bit rnd);
    bit ok;
    ok = 1'b0;
    up_wr_req = 1'b1; up_wr_type = t; up_wr_addr = a; up_wr_wstrb = s; up_wr_data = d;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clock);
      ok = up_wr_rdy;
      step();
      if (rnd) dn_wr_rdy = 1'($urandom_range(0, 1));
    end
    up_wr_req = 1'b0;
    chk("push_wait", ok, 1'b1);
  endtask

  // Let the bridge accept until the buffer is empty
  task automatic drain(input bit rnd);
    bit done;
    done = 1'b0;
    for (int n = 0; n < 200 && !done; n++) begin
      dn_wr_rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clock);
      done = write_buffer_empty;
      step();
    end
    dn_wr_rdy = 1'b0;
    chk("drain_wait", done, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    up_rd_req = 1'b0; up_rd_type = TYPE_LINE; up_rd_addr = 32'h0; dn_rd_rdy = 1'b0;
    up_wr_req = 1'b0; up_wr_type = TYPE_LINE; up_wr_addr = 32'h0;
    up_wr_wstrb = 4'h0; up_wr_data = 128'h0; dn_wr_rdy = 1'b0;
    step(); step();
    @(negedge clock);
    chk("rst_wr_req", dn_wr_req, 1'b0);
    chk("rst_empty", write_buffer_empty, 1'b1);
    chk("rst_wr_rdy", up_wr_rdy, 1'b1);
    chk("rst_rd_req", dn_rd_req, 1'b0);
    step();
    reset = 1'b0;
    step();

    // Line writeback then refill of the same line
    push(TYPE_LINE, 32'h1000, 4'hF, D1, 1'b0);
    up_rd_req = 1'b1; up_rd_type = TYPE_LINE; up_rd_addr = 32'h1008; dn_rd_rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("t1_rd_stall", dn_rd_req, 1'b0);
      chk("t1_wr_data", dn_wr_data, D1);
      step();
    end
    dn_wr_rdy = 1'b1;
    @(negedge clock);
    chk("t1_still_stall", dn_rd_req, 1'b0);
    step();
    dn_wr_rdy = 1'b0;
    @(negedge clock);
    chk("t1_rd_release", dn_rd_req, 1'b1);
    chk("t1_rd_rdy", up_rd_rdy, 1'b1);
    step();
    up_rd_req = 1'b0;

    // Independent read passes a pending write
    push(TYPE_LINE, 32'h1000, 4'hF, D2, 1'b0);
    up_rd_req = 1'b1; up_rd_type = TYPE_LINE; up_rd_addr = 32'h2000; dn_rd_rdy = 1'b1;
    @(negedge clock);
    chk("t2_rd_req", dn_rd_req, 1'b1);
    chk("t2_rd_rdy", up_rd_rdy, 1'b1);
    step();
    dn_rd_rdy = 1'b0;
    @(negedge clock);
    chk("t2_rd_req_hold", dn_rd_req, 1'b1);
    chk("t2_rd_rdy_low", up_rd_rdy, 1'b0);
    step();
    up_rd_req = 1'b0;
    drain(1'b0);

    // Fill to full, then a push alongside a pop is refused
    popped.delete();
    for (int i = 0; i < 4; i++) push(TYPE_WORD, 32'h500 + 32'(16 * i), 4'hF, 128'(i), 1'b0);
    @(negedge clock);
    chk("t3_full", up_wr_rdy, 1'b0);
    chk("t3_head", dn_wr_addr, 32'h500);
    up_wr_req = 1'b1; up_wr_type = TYPE_WORD; up_wr_addr = 32'h5F0;
    up_wr_wstrb = 4'hF; up_wr_data = 128'd99; dn_wr_rdy = 1'b1;
    step();
    up_wr_req = 1'b0; dn_wr_rdy = 1'b0;
    @(negedge clock);
    chk("t3_rdy_after_pop", up_wr_rdy, 1'b1);
    chk("t3_head2", dn_wr_addr, 32'h510);
    step();
    drain(1'b0);
    chk("t3_pop_count", popped.size(), 4);
    for (int i = 0; i < 4 && i < popped.size(); i++)
      chk("t3_pop_order", popped[i], 32'h500 + 32'(16 * i));

    // Wrap and order with random bridge back-pressure
    popped.delete();
    for (int i = 0; i < 10; i++) push(TYPE_WORD, 32'h100 + 32'(4 * i), 4'hF, 128'(i), 1'b1);
    drain(1'b1);
    @(negedge clock);
    chk("t4_empty", write_buffer_empty, 1'b1);
    chk("t4_pop_count", popped.size(), 10);
    for (int i = 0; i < 10 && i < popped.size(); i++)
      chk("t4_pop_order", popped[i], 32'h100 + 32'(4 * i));
    step();

    // Uncached read waits for all writes
    push(TYPE_LINE, 32'h3000, 4'hF, D3, 1'b0);
    up_rd_req = 1'b1; up_rd_type = TYPE_WORD; up_rd_addr = 32'h8000; dn_rd_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("t5_unc_stall", dn_rd_req, 1'b0);
      step();
    end
    dn_wr_rdy = 1'b1;
    step();
    dn_wr_rdy = 1'b0;
    @(negedge clock);
    chk("t5_unc_empty", write_buffer_empty, 1'b1);
    chk("t5_unc_release", dn_rd_req, 1'b1);
    step();
    up_rd_req = 1'b0;

    // Same-cycle push to the line being read
    up_rd_req = 1'b1; up_rd_type = TYPE_LINE; up_rd_addr = 32'h4004;
    up_wr_req = 1'b1; up_wr_type = TYPE_LINE; up_wr_addr = 32'h4000;
    up_wr_wstrb = 4'hF; up_wr_data = D3;
    @(negedge clock);
    chk("t5c_empty", write_buffer_empty, 1'b1);
    chk("t5c_stall", dn_rd_req, 1'b0);
    step();
    up_wr_req = 1'b0;
    @(negedge clock);
    chk("t5c_stall_buf", dn_rd_req, 1'b0);
    chk("t5c_wr_req", dn_wr_req, 1'b1);
    step();
    up_rd_req = 1'b0;
    drain(1'b0);

    // Reset with entries pending
    for (int i = 0; i < 3; i++) push(TYPE_WORD, 32'h700 + 32'(16 * i), 4'h3, 128'(i + 5), 1'b0);
    @(negedge clock);
    chk("t6_pending", dn_wr_req, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clock);
    chk("t6_wr_req", dn_wr_req, 1'b0);
    chk("t6_empty", write_buffer_empty, 1'b1);
    chk("t6_wr_rdy", up_wr_rdy, 1'b1);
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dcache_wr_buf.md
Name: dcache_wr_buf

Overview:
- Posted-write buffer between the dcache miss/writeback port and the axi_bridge data port.
- Absorbs dirty-line writebacks and uncached stores, so the dcache can issue its refill read without waiting for the AXI write to finish.
- Passes read requests through, and holds back any read that would overtake a pending write to the same line, or any uncached read while writes are pending.

Parameters:
- DEPTH, 4, number of buffered write entries (power of two, ≥2).
- MATCH_LSB, 4, lowest address bit compared for RAW hazard (16-byte line granularity).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous active-high reset
- up_rd_req  in  1  read request from dcache
- up_rd_type  in  3  read type; 3'b100 = cache line, else uncached byte/half/word
- up_rd_addr  in  32  read address
- up_rd_rdy  out  1  read accepted this cycle
- dn_rd_req  out  1  read request to axi_bridge
- dn_rd_type  out  3  equals up_rd_type
- dn_rd_addr  out  32  equals up_rd_addr
- dn_rd_rdy  in  1  axi_bridge read ready
- up_wr_req  in  1  write request from dcache
- up_wr_type  in  3  write type (same encoding as reads)
- up_wr_addr  in  32  write address
- up_wr_wstrb  in  4  byte strobe (uncached writes)
- up_wr_data  in  128  write data (line, or word in [31:0])
- up_wr_rdy  out  1  buffer can accept a write
- dn_wr_req  out  1  head entry valid to axi_bridge
- dn_wr_type  out  3  head entry type
- dn_wr_addr  out  32  head entry address
- dn_wr_wstrb  out  4  head entry strobe
- dn_wr_data  out  128  head entry data
- dn_wr_rdy  in  1  axi_bridge accepts write
- write_buffer_empty  out  1  no entry pending

Behaviour:
- Clock/reset: one clock (clock). Reset is synchronous and active-high (reset).
- Handshake: a transfer occurs on any cycle with req && rdy. The requester holds req and its fields stable until accepted.
- Storage: circular FIFO with head and tail pointers plus count (0..DEPTH). Each entry is {type, addr, wstrb, data} = 167 bits, plus a per-entry valid bit for hazard compare.
- Push: up_wr_rdy = (count != DEPTH), independent of dn_wr_rdy. When full, no same-cycle push-through is allowed even if a pop occurs.
- Pop: dn_wr_req = (count != 0). The dn_wr_* fields are driven from the head entry. Pop happens on dn_wr_req && dn_wr_rdy.
- Latency: a write accepted at cycle N appears on dn_wr_req at N+1 at the earliest. There is no combinational bypass.
- Simultaneous push and pop: count is unchanged and both pointers advance. Pointers wrap modulo DEPTH.
- write_buffer_empty = (count == 0), registered state only. It is 0 in the cycle after a push into an empty buffer.
- Read hazard (combinational) is raised when any of these holds:
  - (a) a valid entry has addr[31:MATCH_LSB] == up_rd_addr[31:MATCH_LSB];
  - (b) up_rd_type != 3'b100 && count != 0 (strong ordering for uncached);
  - (c) an accepting push this cycle (up_wr_req && up_wr_rdy) matches per (a) or (b).
- Read gating: dn_rd_req = up_rd_req && !hazard; up_rd_rdy = dn_rd_rdy && !hazard. dn_rd_type and dn_rd_addr are straight wires.
- Return path: ret_valid, ret_last and ret_data are not routed through this block.
- Reset values: count = 0, pointers = 0, all entry valids = 0, dn_wr_req = 0, write_buffer_empty = 1, up_wr_rdy = 1. dn_rd_req follows its equation, which is 0 while up_rd_req = 0.
- Reset mid-operation: all pending entries are discarded. A partially accepted AXI write is the bridge's responsibility.
- Deadlock freedom: the write side never depends on the read side, so a stalled read always drains once the matching entries pop.

Decomposition:
- Shared package (cache_pkg), holding:
  - type encodings: TYPE_BYTE = 3'b000, TYPE_HALF = 3'b001, TYPE_WORD = 3'b010, TYPE_LINE = 3'b100;
  - LINE_BYTES = 16;
  - WR_ENTRY_W = 167.
- Sub-module: sync_fifo (WIDTH, DEPTH), exposing count and per-slot valid/data for the hazard compare. dcache_wr_buf adds the hazard and gating logic around it.

Test Plan:
- Line writeback then refill of same line:
  - stimulus: push LINE write to 0x1000, then up_rd_req LINE 0x1008 with dn_wr_rdy = 0 for 5 cycles;
  - required: dn_rd_req = 0 throughout; dn_rd_req = 1 in the cycle after the pop; dn_wr_data[127:0] matches the pushed data.
- Independent read: with a pending write to 0x1000, read LINE 0x2000 → dn_rd_req = 1 and up_rd_rdy = dn_rd_rdy in the same cycle.
- Fill to full: DEPTH = 4, dn_wr_rdy = 0, push 4 writes → up_wr_rdy = 0 after the 4th. Push attempted with simultaneous pop when full → rejected, count = 3 next cycle.
- Wrap and order: push 10 WORD writes (addr 0x100+4i, wstrb 4'hF) with random dn_wr_rdy → popped in order 0..9, write_buffer_empty = 1 after the last pop.
- Uncached ordering: pending write to 0x3000, uncached WORD read to 0x8000 → stalled until write_buffer_empty = 1. Same-cycle push with matching LINE read (case c) → read stalled.
- Reset mid-operation: 3 entries pending, assert reset for 1 cycle → next cycle dn_wr_req = 0, write_buffer_empty = 1, up_wr_rdy = 1.
